mandel_view_ctrl: RTL and testbench



---
 rtl/mandel_pkg.sv | 53 +++++
 rtl/key_event.sv | 38 +++
 rtl/mandel_view_ctrl.sv | 139 +++++++++++++
 tb/tb_mandel_view_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared constants, key bit map, FSM states and the clamp helper
// used by the Mandelbrot view controller.
package mandel_pkg;

    localparam int COORD_W = 32;

    localparam logic [COORD_W-1:0] CX_INIT    = 32'hF800_0000;
    localparam logic [COORD_W-1:0] SCALE_INIT = 32'h004C_CCCD;
    localparam logic [COORD_W-1:0] SCALE_MIN  = 32'h0000_0100;
    localparam logic [COORD_W-1:0] LIMIT      = 32'h2000_0000;

    localparam int KEY_F = 0;
    localparam int KEY_R = 1;
    localparam int KEY_D = 2;
    localparam int KEY_S = 3;
    localparam int KEY_A = 4;
    localparam int KEY_W = 5;

    // Digit '1' sits on the top bit, digit '0' (n=10) on bit 6.
    localparam int KEY_DIG0 = 6;
    localparam int KEY_DIG9 = 7;
    localparam int KEY_DIG8 = 8;
    localparam int KEY_DIG7 = 9;
    localparam int KEY_DIG6 = 10;
    localparam int KEY_DIG5 = 11;
    localparam int KEY_DIG4 = 12;
    localparam int KEY_DIG3 = 13;
    localparam int KEY_DIG2 = 14;
    localparam int KEY_DIG1 = 15;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_APPLY,
        S_START,
        S_WAIT
    } view_state_t;

    // Saturate a one-bit-wider sum back into [-LIMIT, +LIMIT].
    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic signed [COORD_W:0] v
    );
        logic signed [COORD_W:0] lim;
        lim = $signed({1'b0, LIMIT});
        if (v > lim)
            return LIMIT;
        else if (v < -lim)
            return -LIMIT;
        else
            return v[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/key_event.sv
// Key edge detection and held-key auto-repeat for the view controller.
// Ports: clock, resetn, keys[15:0], idle in; key_edge, held, repeat_fire out.
module key_event #(
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] keys,
    input  logic        idle,
    output logic [15:0] key_edge,
    output logic [5:0]  held,
    output logic        repeat_fire
);

    localparam int CW = $clog2(REPEAT_CYCLES + 1);

    logic [15:0]   keys_q;
    logic [CW-1:0] cnt;

    assign key_edge    = keys & ~keys_q;
    assign held        = keys[5:0];
    assign repeat_fire = idle && (|held)
                      && (cnt == CW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            keys_q <= '0;
            cnt    <= '0;
        end else begin
            keys_q <= keys;
            if (!idle || (|key_edge) || !(|held) || repeat_fire)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mandel_view_ctrl.sv
// Turns key state into Mandelbrot view parameters and sequences renders.
// Ports: clock, resetn, keys, render_done in; render_start, busy, view out.
module mandel_view_ctrl
    import mandel_pkg::*;
#(
    parameter int ITER_W        = 10,
    parameter int STEP_SHIFT    = 4,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [15:0]        keys,
    input  logic               render_done,
    output logic               render_start,
    output logic               busy,
    output logic [COORD_W-1:0] center_x,
    output logic [COORD_W-1:0] center_y,
    output logic [COORD_W-1:0] scale,
    output logic [ITER_W-1:0]  max_iter
);

    view_state_t state, state_n;

    logic [15:0] key_edge;
    logic [5:0]  held;
    logic        repeat_fire;
    logic [15:0] pending;
    logic [15:0] act;
    logic [15:0] trig;

    key_event #(
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_key_event (
        .clock      (clock),
        .resetn     (resetn),
        .keys       (keys),
        .idle       (state == S_IDLE),
        .key_edge   (key_edge),
        .held       (held),
        .repeat_fire(repeat_fire)
    );

    assign trig = pending | key_edge
                | ({10'b0, held} & {16{repeat_fire}});

    assign busy         = (state != S_IDLE);
    assign render_start = (state == S_START);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= S_INIT;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_INIT:  state_n = S_START;
            S_IDLE:  if (|trig) state_n = S_APPLY;
            S_APPLY: state_n = S_START;
            S_START: state_n = S_WAIT;
            S_WAIT:  if (render_done) state_n = S_IDLE;
            default: state_n = S_INIT;
        endcase
    end

    logic        [COORD_W:0]   step;
    logic signed [COORD_W:0]   dx, dy, x_sum, y_sum;
    logic        [COORD_W:0]   sc_up;
    logic        [COORD_W-1:0] sc_dn, scale_n;
    logic        [ITER_W-1:0]  iter_n;

    assign step = {1'b0, scale} << STEP_SHIFT;

    always_comb begin
        dx = '0;
        dy = '0;
        if (act[KEY_D] && !act[KEY_A])
            dx = $signed(step);
        else if (act[KEY_A] && !act[KEY_D])
            dx = -$signed(step);
        if (act[KEY_W] && !act[KEY_S])
            dy = $signed(step);
        else if (act[KEY_S] && !act[KEY_W])
            dy = -$signed(step);
        x_sum = $signed({center_x[COORD_W-1], center_x}) + dx;
        y_sum = $signed({center_y[COORD_W-1], center_y}) + dy;
    end

    always_comb begin
        sc_up   = {scale, 1'b0};
        sc_dn   = scale >> 1;
        scale_n = scale;
        if (act[KEY_R] && !act[KEY_F])
            scale_n = (sc_dn < SCALE_MIN) ? SCALE_MIN : sc_dn;
        else if (act[KEY_F] && !act[KEY_R])
            scale_n = (sc_up > {1'b0, SCALE_INIT})
                    ? SCALE_INIT : sc_up[COORD_W-1:0];
    end

    // Ascending scan: the highest set digit bit (smallest n) wins.
    always_comb begin
        iter_n = max_iter;
        for (int b = KEY_DIG0; b <= KEY_DIG1; b++)
            if (act[b])
                iter_n = ITER_W'(32 * (KEY_DIG1 + 1 - b));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending  <= '0;
            act      <= '0;
            center_x <= CX_INIT;
            center_y <= '0;
            scale    <= SCALE_INIT;
            max_iter <= ITER_W'(64);
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|trig) begin
                        act     <= trig;
                        pending <= '0;
                    end
                end
                S_APPLY: begin
                    pending  <= pending | key_edge;
                    center_x <= clamp_coord(x_sum);
                    center_y <= clamp_coord(y_sum);
                    scale    <= scale_n;
                    max_iter <= iter_n;
                end
                S_START, S_WAIT: pending <= pending | key_edge;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mandel_view_ctrl.sv
// Directed self-checking bench for mandel_view_ctrl.
// A background responder answers each render_start with done 5 cycles later.
module tb_mandel_view_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] keys = '0;
    logic        render_done = 1'b0;
    logic        render_start, busy;
    logic [31:0] center_x, center_y, scale;
    logic [9:0]  max_iter;

    int pass_cnt = 0;
    int total    = 0;
    int done_cnt = 0;

    localparam logic [15:0] K_F  = 16'h0001;
    localparam logic [15:0] K_R  = 16'h0002;
    localparam logic [15:0] K_D  = 16'h0004;
    localparam logic [15:0] K_S  = 16'h0008;
    localparam logic [15:0] K_A  = 16'h0010;
    localparam logic [15:0] K_W  = 16'h0020;
    localparam logic [15:0] K_D0 = 16'h0040;
    localparam logic [15:0] K_D1 = 16'h8000;
    localparam logic [15:0] K_D3 = 16'h2000;

    localparam logic [31:0] CX0 = 32'hF800_0000;
    localparam logic [31:0] SC0 = 32'h004C_CCCD;

    mandel_view_ctrl #(
        .ITER_W(10),
        .STEP_SHIFT(4),
        .REPEAT_CYCLES(100)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .keys        (keys),
        .render_done (render_done),
        .render_start(render_start),
        .busy        (busy),
        .center_x    (center_x),
        .center_y    (center_y),
        .scale       (scale),
        .max_iter    (max_iter)
    );

    always #10 clock = ~clock;

    always @(negedge clock) begin
        render_done = 1'b0;
        if (!resetn) begin
            done_cnt = 0;
        end else if (done_cnt > 0) begin
            done_cnt = done_cnt - 1;
            if (done_cnt == 0) render_done = 1'b1;
        end else if (render_start) begin
            done_cnt = 5;
        end
    end

    task automatic wait_start(input int max_c, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_c && !found; i++) begin
            @(negedge clock);
            if (render_start) found = 1'b1;
        end
    endtask

    task automatic wait_idle(input int max_c, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_c && !found; i++) begin
            @(negedge clock);
            if (!busy) found = 1'b1;
        end
    endtask

    task automatic do_reset();
        bit f;
        keys = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        wait_idle(30, f);
    endtask

    task automatic test_reset();
        bit f;
        keys = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if (render_start !== 1'b0 || busy !== 1'b1)
            $display("FAIL rst_ctl: start=%b busy=%b want 0 1",
                     render_start, busy);
        else pass_cnt++;
        total++;
        if (center_x !== CX0 || center_y !== 32'h0)
            $display("FAIL rst_ctr: x=%h y=%h want %h 0",
                     center_x, center_y, CX0);
        else pass_cnt++;
        total++;
        if (scale !== SC0 || max_iter !== 10'd64)
            $display("FAIL rst_scl: scale=%h it=%0d want %h 64",
                     scale, max_iter, SC0);
        else pass_cnt++;
        resetn = 1'b1;
        @(negedge clock);
        total++;
        if (render_start !== 1'b1)
            $display("FAIL rst_start: got %b want 1", render_start);
        else pass_cnt++;
        wait_idle(20, f);
        total++;
        if (f !== 1'b1 || busy !== 1'b0)
            $display("FAIL rst_idle: found=%b busy=%b want 1 0", f, busy);
        else pass_cnt++;
    endtask

    task automatic test_single_pan();
        do_reset();
        keys = K_D;
        @(negedge clock);
        total++;
        if (render_start !== 1'b0 || busy !== 1'b1)
            $display("FAIL pan_apply: start=%b busy=%b want 0 1",
                     render_start, busy);
        else pass_cnt++;
        keys = '0;
        @(negedge clock);
        total++;
        if (render_start !== 1'b1)
            $display("FAIL pan_start: got %b want 1", render_start);
        else pass_cnt++;
        total++;
        if (center_x !== 32'hFCCC_CCD0 || center_y !== 32'h0)
            $display("FAIL pan_xy: x=%h y=%h want fccccd0 0",
                     center_x, center_y);
        else pass_cnt++;
        total++;
        if (scale !== SC0 || max_iter !== 10'd64)
            $display("FAIL pan_keep: scale=%h it=%0d want %h 64",
                     scale, max_iter, SC0);
        else pass_cnt++;
    endtask

    task automatic test_opposing();
        bit f;
        do_reset();
        keys = K_W | K_S;
        @(negedge clock);
        keys = '0;
        wait_start(5, f);
        total++;
        if (f !== 1'b1 || center_y !== 32'h0 || center_x !== CX0)
            $display("FAIL opp_ws: found=%b x=%h y=%h want 1 %h 0",
                     f, center_x, center_y, CX0);
        else pass_cnt++;
        wait_idle(20, f);
        wait_start(15, f);
        total++;
        if (f !== 1'b0)
            $display("FAIL opp_once: extra render=%b want 0", f);
        else pass_cnt++;
        keys = K_F;
        @(negedge clock);
        keys = '0;
        wait_start(5, f);
        total++;
        if (f !== 1'b1 || scale !== SC0)
            $display("FAIL opp_fcap: found=%b scale=%h want 1 %h",
                     f, scale, SC0);
        else pass_cnt++;
        wait_idle(20, f);
    endtask

    task automatic test_auto_repeat();
        bit f;
        int n;
        logic [31:0] sc [0:3];
        do_reset();
        n = 0;
        keys = K_R;
        for (int i = 0; i < 250; i++) begin
            @(negedge clock);
            if (render_start) begin
                if (n < 4) sc[n] = scale;
                n++;
            end
        end
        keys = '0;
        wait_idle(20, f);
        total++;
        if (n !== 3)
            $display("FAIL rep_count: renders=%0d want 3", n);
        else pass_cnt++;
        if (n >= 3) begin
            total++;
            if (sc[0] !== 32'h0026_6666 || sc[1] !== 32'h0013_3333
                || sc[2] !== 32'h0009_9999)
                $display("FAIL rep_scale: %h %h %h want 266666 133333 99999",
                         sc[0], sc[1], sc[2]);
            else pass_cnt++;
        end
    endtask

    task automatic test_queuing();
        bit f;
        keys = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        @(negedge clock);
        keys = K_A;
        @(negedge clock);
        keys = K_A | K_D3;
        total++;
        if (center_x !== CX0 || max_iter !== 10'd64 || busy !== 1'b1)
            $display("FAIL q_stable: x=%h it=%0d busy=%b want %h 64 1",
                     center_x, max_iter, busy, CX0);
        else pass_cnt++;
        @(negedge clock);
        keys = '0;
        wait_start(20, f);
        total++;
        if (f !== 1'b1 || center_x !== 32'hF333_3330 || max_iter !== 10'd96)
            $display("FAIL q_apply: found=%b x=%h it=%0d want 1 f3333330 96",
                     f, center_x, max_iter);
        else pass_cnt++;
        wait_idle(20, f);
        wait_start(15, f);
        total++;
        if (f !== 1'b0)
            $display("FAIL q_once: extra render=%b want 0", f);
        else pass_cnt++;
    endtask

    task automatic test_digits();
        bit f;
        do_reset();
        keys = K_D1 | K_D0;
        @(negedge clock);
        keys = '0;
        wait_start(5, f);
        total++;
        if (f !== 1'b1 || max_iter !== 10'd32)
            $display("FAIL dig_pri: found=%b it=%0d want 1 32", f, max_iter);
        else pass_cnt++;
        wait_idle(20, f);
        keys = K_D0;
        @(negedge clock);
        keys = '0;
        wait_start(5, f);
        total++;
        if (f !== 1'b1 || max_iter !== 10'd320)
            $display("FAIL dig_zero: found=%b it=%0d want 1 320", f, max_iter);
        else pass_cnt++;
        wait_idle(20, f);
    endtask

    task automatic test_clamp();
        bit f;
        logic [31:0] xs [1:10];
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            keys = K_D;
            @(negedge clock);
            keys = '0;
            wait_start(5, f);
            xs[i] = center_x;
            wait_idle(20, f);
        end
        total++;
        if (xs[8] !== 32'h1E66_6680)
            $display("FAIL clamp_8: x=%h want 1e666680", xs[8]);
        else pass_cnt++;
        total++;
        if (xs[9] !== 32'h2000_0000 || xs[10] !== 32'h2000_0000)
            $display("FAIL clamp_sat: x9=%h x10=%h want 20000000",
                     xs[9], xs[10]);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bit f;
        do_reset();
        keys = K_D;
        @(negedge clock);
        keys = K_R;
        @(negedge clock);
        keys = '0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (busy !== 1'b1 || center_x !== 32'hFCCC_CCD0)
            $display("FAIL ar_pre: busy=%b x=%h want 1 fccccd0",
                     busy, center_x);
        else pass_cnt++;
        resetn = 1'b0;
        #1;
        total++;
        if (center_x !== CX0 || scale !== SC0 || center_y !== 32'h0
            || max_iter !== 10'd64 || busy !== 1'b1 || render_start !== 1'b0)
            $display("FAIL ar_now: x=%h s=%h y=%h it=%0d b=%b st=%b",
                     center_x, scale, center_y, max_iter, busy, render_start);
        else pass_cnt++;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        total++;
        if (render_start !== 1'b1)
            $display("FAIL ar_start: got %b want 1", render_start);
        else pass_cnt++;
        wait_idle(20, f);
        wait_start(15, f);
        total++;
        if (f !== 1'b0 || center_x !== CX0)
            $display("FAIL ar_quiet: extra=%b x=%h want 0 %h",
                     f, center_x, CX0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_pan();
        test_opposing();
        test_auto_repeat();
        test_queuing();
        test_digits();
        test_clamp();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
